// File: rtl/maze_tile_renderer.sv
// Frame-scan tile renderer: walks every display pixel, looks up the maze cell and
// tile-ROM pixel under it (with player overlay) and streams RGB565 to LT24Display.
module maze_tile_renderer #(
    parameter int unsigned WIDTH       = 240,
    parameter int unsigned HEIGHT      = 320,
    parameter int unsigned TILE        = 8,
    parameter int unsigned MAZE_W      = 30,
    parameter int unsigned MAZE_H      = 40,
    parameter int unsigned CELL_BITS   = 1,
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
    input  logic                            clock,
    input  logic                            resetApp,
    input  logic                            render_start,
    output logic                            render_busy,
    output logic                            render_done,
    output logic [10:0]                     maze_addr,
    input  logic [CELL_BITS-1:0]            maze_data,
    input  logic [$clog2(MAZE_W)-1:0]       player_x,
    input  logic [$clog2(MAZE_H)-1:0]       player_y,
    output logic [CELL_BITS:0]              tile_sel,
    output logic [$clog2(TILE*TILE)-1:0]    tile_addr,
    input  logic [15:0]                     tile_pixel,
    output logic [7:0]                      xAddr,
    output logic [8:0]                      yAddr,
    output logic [15:0]                     pixelData,
    output logic                            pixelWrite,
    input  logic                            pixelReady
);

    localparam int unsigned TSH = $clog2(TILE);
    localparam int unsigned TAW = $clog2(TILE*TILE);
    localparam int unsigned CW  = $clog2(MEM_LATENCY+1);

    typedef enum logic [2:0] {IDLE, CELL, TILE_LOOKUP, WAIT, WRITE, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    int unsigned     cx, cy, ncx, ncy;
    logic            in_maze, next_in_maze, player_hit, last_px;
    logic [7:0]      nx;
    logic [8:0]      ny;
    logic [10:0]     next_idx;
    logic [TAW-1:0]  tile_idx;

    always_comb begin
        cx         = 32'(xAddr) >> TSH;
        cy         = 32'(yAddr) >> TSH;
        in_maze    = (cx < MAZE_W) && (cy < MAZE_H);
        player_hit = (cx == 32'(player_x)) && (cy == 32'(player_y));
        last_px    = (32'(xAddr) == WIDTH - 1) && (32'(yAddr) == HEIGHT - 1);
        if (32'(xAddr) == WIDTH - 1) begin
            nx = '0;
            ny = yAddr + 9'd1;
        end else begin
            nx = xAddr + 8'd1;
            ny = yAddr;
        end
        ncx          = 32'(nx) >> TSH;
        ncy          = 32'(ny) >> TSH;
        next_in_maze = (ncx < MAZE_W) && (ncy < MAZE_H);
        next_idx     = 11'(ncx) + 11'(MAZE_W) * 11'(ncy);
        tile_idx     = TAW'(32'(xAddr) & (TILE - 1))
                     + TAW'(TILE) * TAW'(32'(yAddr) & (TILE - 1));
    end

    // maze_addr is registered on the way into CELL so the memory sees it during
    // CELL itself; out-of-maze pixels leave it untouched.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state       <= IDLE;
            cnt         <= '0;
            xAddr       <= '0;
            yAddr       <= '0;
            maze_addr   <= '0;
            tile_sel    <= '0;
            tile_addr   <= '0;
            pixelData   <= '0;
            pixelWrite  <= 1'b0;
            render_busy <= 1'b0;
            render_done <= 1'b0;
        end else begin
            render_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (render_start) begin
                        xAddr       <= '0;
                        yAddr       <= '0;
                        maze_addr   <= '0;
                        render_busy <= 1'b1;
                        state       <= CELL;
                    end
                end
                CELL: begin
                    if (in_maze) begin
                        cnt   <= CW'(1);
                        state <= TILE_LOOKUP;
                    end else begin
                        pixelData  <= BG_COLOUR;
                        pixelWrite <= 1'b1;
                        state      <= WRITE;
                    end
                end
                TILE_LOOKUP: begin
                    if (cnt == CW'(MEM_LATENCY)) begin
                        tile_sel  <= {player_hit, maze_data};
                        tile_addr <= tile_idx;
                        cnt       <= '0;
                        state     <= WAIT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (cnt == CW'(MEM_LATENCY)) begin
                        pixelData  <= tile_pixel;
                        pixelWrite <= 1'b1;
                        state      <= WRITE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WRITE: begin
                    if (pixelReady) begin
                        pixelWrite <= 1'b0;
                        if (last_px) begin
                            render_done <= 1'b1;
                            render_busy <= 1'b0;
                            state       <= DONE;
                        end else begin
                            xAddr <= nx;
                            yAddr <= ny;
                            if (next_in_maze)
                                maze_addr <= next_idx;
                            state <= CELL;
                        end
                    end
                end
                DONE: begin
                    xAddr <= '0;
                    yAddr <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Bench for maze_tile_renderer: a small-display instance for frame/table/stall/reset
// checks and a narrow-maze, latency-3 instance for background and cadence checks.
module tb_maze_tile_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rom(input logic [1:0] s, input logic [5:0] a);
        return {1'b1, 5'b0, s, 2'b0, a};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- instance A: 40x24 display, defaults otherwise
    logic        rstA, a_start, a_busy, a_done, a_pw, a_rdy;
    logic [10:0] a_maddr;
    logic [0:0]  a_mdata, a_mp0, a_mp1;
    logic [4:0]  a_px;
    logic [5:0]  a_py;
    logic [1:0]  a_sel;
    logic [5:0]  a_taddr;
    logic [15:0] a_tpix, a_tp0, a_tp1, a_pd;
    logic [7:0]  a_x;
    logic [8:0]  a_y;
    logic [0:0]  a_mem [2048];

    maze_tile_renderer #(.WIDTH(40), .HEIGHT(24)) u_a (
        .clock(clk), .resetApp(rstA), .render_start(a_start), .render_busy(a_busy),
        .render_done(a_done), .maze_addr(a_maddr), .maze_data(a_mdata),
        .player_x(a_px), .player_y(a_py), .tile_sel(a_sel), .tile_addr(a_taddr),
        .tile_pixel(a_tpix), .xAddr(a_x), .yAddr(a_y), .pixelData(a_pd),
        .pixelWrite(a_pw), .pixelReady(a_rdy));

    always @(posedge clk) begin
        a_mp0 <= a_mem[a_maddr];
        a_mp1 <= a_mp0;
        a_tp0 <= rom(a_sel, a_taddr);
        a_tp1 <= a_tp0;
    end
    assign a_mdata = a_mp1;
    assign a_tpix  = a_tp1;

    // ---------------- instance B: maze 3 cells wide, latency 3
    logic        rstB, b_start, b_busy, b_done, b_pw, b_rdy;
    logic [10:0] b_maddr;
    logic [0:0]  b_mdata, b_mp0, b_mp1, b_mp2;
    logic [1:0]  b_px;
    logic [5:0]  b_py;
    logic [1:0]  b_sel;
    logic [5:0]  b_taddr;
    logic [15:0] b_tpix, b_tp0, b_tp1, b_tp2, b_pd;
    logic [7:0]  b_x;
    logic [8:0]  b_y;
    logic [0:0]  b_mem [2048];

    maze_tile_renderer #(.WIDTH(40), .HEIGHT(16), .MAZE_W(3), .MEM_LATENCY(3)) u_b (
        .clock(clk), .resetApp(rstB), .render_start(b_start), .render_busy(b_busy),
        .render_done(b_done), .maze_addr(b_maddr), .maze_data(b_mdata),
        .player_x(b_px), .player_y(b_py), .tile_sel(b_sel), .tile_addr(b_taddr),
        .tile_pixel(b_tpix), .xAddr(b_x), .yAddr(b_y), .pixelData(b_pd),
        .pixelWrite(b_pw), .pixelReady(b_rdy));

    always @(posedge clk) begin
        b_mp0 <= b_mem[b_maddr];
        b_mp1 <= b_mp0;
        b_mp2 <= b_mp1;
        b_tp0 <= rom(b_sel, b_taddr);
        b_tp1 <= b_tp0;
        b_tp2 <= b_tp1;
    end
    assign b_mdata = b_mp2;
    assign b_tpix  = b_tp2;

    // ---------------- A monitor: raster order, pixel model, done timing, captures
    int a_writes, a_dones, a_pix_err, a_order_err, a_done_miss, a_ex, a_ey;
    int ax, ay;
    bit a_prev_last, a_hit;
    logic [10:0] cap_ma [40][24];
    logic [1:0]  cap_sel[40][24];
    logic [5:0]  cap_ta [40][24];
    logic [15:0] cap_pd [40][24];

    always @(negedge clk) begin
        if (rstA) begin
            a_prev_last = 1'b0;
        end else begin
            if (a_prev_last && !a_done) a_done_miss++;
            if (a_done) a_dones++;
            a_prev_last = 1'b0;
            if (a_pw && a_rdy) begin
                ax = int'(a_x);
                ay = int'(a_y);
                if (ax != a_ex || ay != a_ey) a_order_err++;
                if (ax < 40 && ay < 24) begin
                    cap_ma[ax][ay]  = a_maddr;
                    cap_sel[ax][ay] = a_sel;
                    cap_ta[ax][ay]  = a_taddr;
                    cap_pd[ax][ay]  = a_pd;
                    a_hit = (ax / 8 == int'(a_px)) && (ay / 8 == int'(a_py));
                    if (a_pd !== rom({a_hit, a_mem[ax / 8 + 30 * (ay / 8)]},
                                     6'((ax % 8) + 8 * (ay % 8))))
                        a_pix_err++;
                end else begin
                    a_pix_err++;
                end
                a_writes++;
                a_prev_last = (ax == 39 && ay == 23);
                if (a_ex == 39) begin a_ex = 0; a_ey++; end else a_ex++;
            end
        end
    end

    // ---------------- B monitor: background, maze_addr hold, cadence
    int b_writes, b_dones, b_data_err, b_lat_n, b_lat_err, b_bg_n, b_bg_err, b_last_xfer;
    int bx, by, bd;
    bit b_seen, b_pw_prev, b_hit;

    always @(negedge clk) begin
        if (rstB) begin
            b_pw_prev = 1'b0;
        end else begin
            if (b_done) b_dones++;
            if (b_pw && !b_pw_prev && b_seen) begin
                bd = cyc - b_last_xfer - 1;
                if (b_x < 8'd24) begin
                    b_lat_n++;
                    if (bd != 8) b_lat_err++;
                end else begin
                    b_bg_n++;
                    if (bd != 1) b_bg_err++;
                end
            end
            b_pw_prev = b_pw;
            if (b_pw && b_rdy) begin
                bx = int'(b_x);
                by = int'(b_y);
                if (bx >= 24) begin
                    if (b_pd !== 16'h0000 || int'(b_maddr) != 2 + 3 * (by / 8)) b_data_err++;
                end else begin
                    b_hit = (bx / 8 == int'(b_px)) && (by / 8 == int'(b_py));
                    if (int'(b_maddr) != bx / 8 + 3 * (by / 8)) b_data_err++;
                    if (b_pd !== rom({b_hit, b_mem[bx / 8 + 3 * (by / 8)]},
                                     6'((bx % 8) + 8 * (by % 8))))
                        b_data_err++;
                end
                b_writes++;
                b_last_xfer = cyc;
                b_seen = 1'b1;
            end
        end
    end

    // ---------------- stimulus table
    typedef struct {
        int frame;
        int x;
        int y;
        int maddr;
        int sel;
        int taddr;
    } vec_t;
    vec_t vecs[12];

    task automatic a_clear();
        a_writes = 0; a_dones = 0; a_pix_err = 0; a_order_err = 0;
        a_done_miss = 0; a_ex = 0; a_ey = 0;
    endtask

    task automatic a_begin();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic a_wait_frame(input string tag);
        int n;
        n = 0;
        while (a_dones == 0 && n < 12000) begin @(negedge clk); n++; end
        chk({tag, "_finished"}, longint'(n < 12000), 1);
        repeat (4) @(negedge clk);
        chk({tag, "_writes"}, a_writes, 960);
        chk({tag, "_order_err"}, a_order_err, 0);
        chk({tag, "_pixel_err"}, a_pix_err, 0);
        chk({tag, "_done_pulses"}, a_dones, 1);
        chk({tag, "_done_timing"}, a_done_miss, 0);
        chk({tag, "_busy_after"}, a_busy, 0);
        chk({tag, "_cursor_home"}, {a_x, a_y}, 0);
    endtask

    task automatic table_check(input int f);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].frame == f) begin
                chk($sformatf("vec%0d_maddr", i), cap_ma[vecs[i].x][vecs[i].y], vecs[i].maddr);
                chk($sformatf("vec%0d_sel", i), cap_sel[vecs[i].x][vecs[i].y], vecs[i].sel);
                chk($sformatf("vec%0d_taddr", i), cap_ta[vecs[i].x][vecs[i].y], vecs[i].taddr);
                chk($sformatf("vec%0d_pixel", i), cap_pd[vecs[i].x][vecs[i].y],
                    rom(2'(vecs[i].sel), 6'(vecs[i].taddr)));
            end
        end
    endtask

    initial begin
        int n;
        logic [15:0] held;
        int bad;

        rstA = 1'b1; rstB = 1'b1;
        a_start = 1'b0; b_start = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
        a_px = '0; a_py = '0; b_px = '0; b_py = '0;
        for (int i = 0; i < 2048; i++) begin
            a_mem[i] = 1'b0;
            b_mem[i] = 1'(i % 2);
        end
        vecs[0]  = '{1, 0, 0, 0, 2, 0};
        vecs[1]  = '{1, 7, 7, 0, 2, 63};
        vecs[2]  = '{1, 8, 0, 1, 0, 0};
        vecs[3]  = '{1, 0, 8, 30, 0, 0};
        vecs[4]  = '{1, 39, 23, 64, 0, 63};
        vecs[5]  = '{2, 10, 9, 31, 1, 10};
        vecs[6]  = '{2, 8, 8, 31, 1, 0};
        vecs[7]  = '{2, 15, 15, 31, 1, 63};
        vecs[8]  = '{2, 16, 8, 32, 0, 0};
        vecs[9]  = '{2, 33, 17, 64, 2, 9};
        vecs[10] = '{2, 31, 17, 63, 0, 15};
        vecs[11] = '{2, 39, 23, 64, 2, 63};

        repeat (3) @(negedge clk);
        chk("A_reset_outputs", {a_x, a_y, a_maddr, a_sel, a_taddr, a_pd, a_pw, a_busy, a_done}, 0);
        chk("B_reset_outputs", {b_x, b_y, b_maddr, b_sel, b_taddr, b_pd, b_pw, b_busy, b_done}, 0);
        rstA = 1'b0; rstB = 1'b0;
        repeat (2) @(negedge clk);
        chk("A_idle_not_busy", a_busy, 0);

        // frame 1: empty maze, player in cell (0,0)
        a_clear();
        a_begin();
        chk("A_busy_after_start", a_busy, 1);
        a_wait_frame("f1");
        table_check(1);

        // frame 2: wall at cell 31, player (4,2), stray start, display stall at (20,10)
        a_mem[31] = 1'b1; a_px = 5'd4; a_py = 6'd2;
        a_clear();
        a_begin();
        repeat (50) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        n = 0;
        while (!(a_x == 8'd20 && a_y == 9'd10 && !a_pw) && n < 5000) begin @(negedge clk); n++; end
        chk("A_stall_reach", longint'(n < 5000), 1);
        a_rdy = 1'b0;
        n = 0;
        while (!a_pw && n < 30) begin @(negedge clk); n++; end
        chk("A_stall_write_seen", a_pw, 1);
        held = a_pd;
        chk("A_stall_data", held, 16'h8014);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!a_pw || a_pd !== held || a_x != 8'd20) bad++;
        end
        chk("A_stall_hold", bad, 0);
        a_rdy = 1'b1;
        n = 0;
        while (a_x != 8'd21 && n < 20) begin @(negedge clk); n++; end
        chk("A_after_stall_x", a_x, 21);
        a_wait_frame("f2");
        table_check(2);

        // frame 3: reset in WAIT of pixel (12,3)
        a_clear();
        a_begin();
        n = 0;
        while (!(a_x == 8'd12 && a_y == 9'd3) && n < 5000) begin @(negedge clk); n++; end
        chk("A_reset_reach", longint'(n < 5000), 1);
        repeat (3) @(negedge clk);
        chk("A_pre_reset_taddr", a_taddr, 28);
        chk("A_pre_reset_busy", a_busy, 1);
        rstA = 1'b1;
        #1;
        chk("A_async_reset_outputs", {a_x, a_y, a_maddr, a_sel, a_taddr, a_pd, a_pw, a_busy, a_done}, 0);
        repeat (3) @(negedge clk);
        rstA = 1'b0;
        @(negedge clk);

        // frame 4: fresh render after reset starts from (0,0)
        a_clear();
        a_begin();
        a_wait_frame("f4");

        // instance B: background region, maze_addr hold, cadence at latency 3
        b_writes = 0; b_dones = 0; b_data_err = 0; b_lat_n = 0; b_lat_err = 0;
        b_bg_n = 0; b_bg_err = 0; b_seen = 1'b0;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 0;
        while (b_dones == 0 && n < 20000) begin @(negedge clk); n++; end
        chk("B_finished", longint'(n < 20000), 1);
        repeat (4) @(negedge clk);
        chk("B_writes", b_writes, 640);
        chk("B_data_err", b_data_err, 0);
        chk("B_inmaze_count", b_lat_n, 383);
        chk("B_inmaze_latency_err", b_lat_err, 0);
        chk("B_bg_count", b_bg_n, 256);
        chk("B_bg_cadence_err", b_bg_err, 0);
        chk("B_done_pulses", b_dones, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
